// File: rtl/sum_display_driver.sv
// sum_display_driver
// Captures an 8-bit two's-complement result, converts its magnitude to three
// BCD digits with a shift-add-3 engine and scans them, with a sign digit, onto
// a 4-digit multiplexed common-anode 7-segment display.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-low reset
//   load  - single-cycle capture strobe
//   value - two's-complement value, sampled when load=1
//   busy  - conversion in progress (registered)
//   done  - one-cycle pulse when new digits are committed (registered)
//   seg   - segments {g,f,e,d,c,b,a}, active-low (registered)
//   an    - digit enables, active-low; an[3]=sign .. an[0]=ones (registered)
module sum_display_driver #(
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] value,
   output logic       busy,
   output logic       done,
   output logic [6:0] seg,
   output logic [3:0] an
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      SHOW = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   // Digit-register code used as the post-reset "blank" flag.
   localparam logic [3:0] DIG_BLANK = 4'hF;
   localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);

   // One double-dabble iteration: add 3 to each BCD nibble >= 5, then shift.
   function automatic logic [19:0] dabble_step(input logic [19:0] s);
      logic [19:0] a;
      a = s;
      if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
      else                  a[19:16] = a[19:16];
      if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
      else                  a[15:12] = a[15:12];
      if (a[11:8] >= 4'd5)  a[11:8]  = a[11:8] + 4'd3;
      else                  a[11:8]  = a[11:8];
      return {a[18:0], 1'b0};
   endfunction

   // BCD digit to active-low segment code; non-decimal codes show blank.
   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return SEG_BLANK;
      endcase
   endfunction

   state_t      state_r, state_nxt_s;
   logic        neg_r;
   logic [19:0] scratch_r;
   logic [19:0] step_s;
   logic [2:0]  iter_r;
   logic [7:0]  mag_s;
   logic        commit_s;
   logic        busy_nxt_s, done_nxt_s;
   logic        d_s_r;
   logic [3:0]  d_h_r, d_t_r, d_o_r;
   logic [15:0] refresh_r;
   logic [1:0]  idx_r;
   logic [6:0]  seg_nxt_s;
   logic [3:0]  an_nxt_s;
   logic        busy_r, done_r;
   logic [6:0]  seg_r;
   logic [3:0]  an_r;

   // Magnitude of the incoming value and the next scratch contents.
   always_comb begin
      if (value[7]) mag_s = ~value + 8'd1;
      else          mag_s = value;
      step_s = dabble_step(scratch_r);
   end

   // A commit happens on the 8th iteration unless a new load restarts it.
   always_comb begin
      if (state_r == CONV && !load && iter_r == 3'd7) commit_s = 1'b1;
      else                                            commit_s = 1'b0;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) state_r <= IDLE;
      else      state_r <= state_nxt_s;
   end

   // FSM next-state logic; load always (re)starts a conversion.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (load) state_nxt_s = CONV;
            else      state_nxt_s = IDLE;
         end
         CONV: begin
            if (load)          state_nxt_s = CONV;
            else if (commit_s) state_nxt_s = SHOW;
            else               state_nxt_s = CONV;
         end
         SHOW: begin
            if (load) state_nxt_s = CONV;
            else      state_nxt_s = SHOW;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM output logic; values are registered below so busy/done are glitch-free.
   always_comb begin
      if (state_nxt_s == CONV) busy_nxt_s = 1'b1;
      else                     busy_nxt_s = 1'b0;
      done_nxt_s = commit_s;
   end

   // Capture and iteration datapath.
   always_ff @(posedge clk) begin
      if (!rst) begin
         neg_r     <= 1'b0;
         scratch_r <= 20'd0;
         iter_r    <= 3'd0;
      end else if (load) begin
         neg_r     <= value[7];
         scratch_r <= {12'd0, mag_s};
         iter_r    <= 3'd0;
      end else if (state_r == CONV) begin
         neg_r     <= neg_r;
         scratch_r <= step_s;
         iter_r    <= iter_r + 3'd1;
      end else begin
         neg_r     <= neg_r;
         scratch_r <= scratch_r;
         iter_r    <= iter_r;
      end
   end

   // Display digit registers; only updated by a complete conversion.
   always_ff @(posedge clk) begin
      if (!rst) begin
         d_s_r <= 1'b0;
         d_h_r <= DIG_BLANK;
         d_t_r <= DIG_BLANK;
         d_o_r <= DIG_BLANK;
      end else if (commit_s) begin
         d_s_r <= neg_r;
         d_h_r <= step_s[19:16];
         d_t_r <= step_s[15:12];
         d_o_r <= step_s[11:8];
      end else begin
         d_s_r <= d_s_r;
         d_h_r <= d_h_r;
         d_t_r <= d_t_r;
         d_o_r <= d_o_r;
      end
   end

   // Refresh counter and digit index; scanning never stops.
   always_ff @(posedge clk) begin
      if (!rst) begin
         refresh_r <= 16'd0;
         idx_r     <= 2'd0;
      end else if (refresh_r == REFRESH_LAST) begin
         refresh_r <= 16'd0;
         idx_r     <= idx_r + 2'd1;
      end else begin
         refresh_r <= refresh_r + 16'd1;
         idx_r     <= idx_r;
      end
   end

   // Segment/enable selection for the current digit, with leading-zero blanking.
   always_comb begin
      seg_nxt_s = SEG_BLANK;
      an_nxt_s  = 4'b1111;
      case (idx_r)
         2'd0: begin
            an_nxt_s  = 4'b1110;
            seg_nxt_s = seg_code(d_o_r);
         end
         2'd1: begin
            an_nxt_s = 4'b1101;
            if (d_h_r == 4'd0 && d_t_r == 4'd0) seg_nxt_s = SEG_BLANK;
            else                                seg_nxt_s = seg_code(d_t_r);
         end
         2'd2: begin
            an_nxt_s = 4'b1011;
            if (d_h_r == 4'd0) seg_nxt_s = SEG_BLANK;
            else               seg_nxt_s = seg_code(d_h_r);
         end
         2'd3: begin
            an_nxt_s = 4'b0111;
            if (d_s_r) seg_nxt_s = SEG_MINUS;
            else       seg_nxt_s = SEG_BLANK;
         end
         default: begin
            an_nxt_s  = 4'b1111;
            seg_nxt_s = SEG_BLANK;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         seg_r  <= SEG_BLANK;
         an_r   <= 4'b1111;
      end else begin
         busy_r <= busy_nxt_s;
         done_r <= done_nxt_s;
         seg_r  <= seg_nxt_s;
         an_r   <= an_nxt_s;
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign seg  = seg_r;
   assign an   = an_r;

endmodule

// File: tb/tb_sum_display_driver.sv
module tb_sum_display_driver;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SM = 7'b0111111;
   localparam logic [6:0] SB = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load = 1'b0;
   logic [7:0] value = 8'h00;
   logic       busy, done;
   logic [6:0] seg;
   logic [3:0] an;

   int total = 0;
   int bad = 0;

   sum_display_driver #(.REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .load(load), .value(value),
      .busy(busy), .done(done), .seg(seg), .an(an)
   );

   always #5 clk = ~clk;

   // Called at a negedge: pulse load for one edge, return at the next negedge.
   task automatic pulse_load(input logic [7:0] v);
      load  = 1'b1;
      value = v;
      @(negedge clk);
      load  = 1'b0;
   endtask

   // Load v and observe busy/done for 12 cycles after the capture edge.
   task automatic run_conv(input logic [7:0] v, output int busy_n, output int done_n,
                           output int done_at, output int both_n, output int seg7_n);
      busy_n = 0; done_n = 0; done_at = -1; both_n = 0; seg7_n = 0;
      pulse_load(v);
      for (int i = 0; i < 12; i++) begin
         if (busy === 1'b1) busy_n++;
         if (done === 1'b1) begin
            done_n++;
            if (done_at < 0) done_at = i;
         end
         if (busy === 1'b1 && done === 1'b1) both_n++;
         if (seg === S7) seg7_n++;
         @(negedge clk);
      end
   endtask

   // Capture the segment code of each digit; frame[27:21]=sign .. [6:0]=ones.
   task automatic read_frame(output logic [27:0] frame, output bit ok);
      logic [3:0] tgt;
      bit got;
      ok = 1'b1;
      frame = '0;
      for (int d = 0; d < 4; d++) begin
         tgt = ~(4'b0001 << d);
         got = 1'b0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (an === tgt) begin
               frame[d*7 +: 7] = seg;
               got = 1'b1;
            end
         end
         if (!got) ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_an;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (an !== 4'b1111 || seg !== SB || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d an=%b seg=%b busy=%b done=%b want an=1111 seg=1111111 busy=0 done=0",
                     i, an, seg, busy, done);
         end
      end
      rst = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         exp_an = ~(4'b0001 << (k / 4));
         total++;
         if (an !== exp_an || seg !== SB) begin
            bad++;
            $display("FAIL reset_walk k=%0d an=%b seg=%b want an=%b seg=%b", k, an, seg, exp_an, SB);
         end
      end
   endtask

   task automatic check_conv(input string name, input logic [7:0] v, input logic [27:0] exp);
      int bn, dn, da, bo, s7;
      logic [27:0] fr;
      bit ok;
      run_conv(v, bn, dn, da, bo, s7);
      total++;
      if (bn != 8 || dn != 1 || da != 8 || bo != 0) begin
         bad++;
         $display("FAIL %s_timing busy_cycles=%0d done_pulses=%0d done_at=%0d overlap=%0d want 8 1 8 0",
                  name, bn, dn, da, bo);
      end
      read_frame(fr, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s_scan_timeout an never cycled through all digits", name);
      end
      for (int d = 0; d < 4; d++) begin
         total++;
         if (fr[d*7 +: 7] !== exp[d*7 +: 7]) begin
            bad++;
            $display("FAIL %s_digit%0d seg=%b want %b", name, d, fr[d*7 +: 7], exp[d*7 +: 7]);
         end
      end
   endtask

   task automatic test_positive();
      check_conv("pos5", 8'h05, {SB, SB, SB, S5});
   endtask

   task automatic test_negative();
      check_conv("neg13", 8'hF3, {SM, SB, S1, S3});
      check_conv("neg128", 8'h80, {SM, S1, S2, S8});
   endtask

   task automatic test_max_zero();
      check_conv("max127", 8'h7F, {SB, S1, S2, S7});
      check_conv("zero", 8'h00, {SB, SB, SB, S0});
   endtask

   task automatic test_load_during_conv();
      int bn, dn, da, bo, s7, early;
      logic [27:0] fr;
      bit ok;
      early = 0;
      pulse_load(8'h7F);
      for (int i = 0; i < 2; i++) begin
         if (done === 1'b1) early++;
         @(negedge clk);
      end
      run_conv(8'h05, bn, dn, da, bo, s7);
      total++;
      if (early != 0 || dn != 1 || da != 8 || bn != 8) begin
         bad++;
         $display("FAIL restart_timing early_done=%0d done_pulses=%0d done_at=%0d busy_cycles=%0d want 0 1 8 8",
                  early, dn, da, bn);
      end
      total++;
      if (s7 != 0) begin
         bad++;
         $display("FAIL restart_no127 seg7_seen=%0d want 0", s7);
      end
      read_frame(fr, ok);
      total++;
      if (!ok || fr !== {SB, SB, SB, S5}) begin
         bad++;
         $display("FAIL restart_digits frame=%h ok=%0d want %h", fr, ok, {SB, SB, SB, S5});
      end
   endtask

   task automatic test_reset_mid_conv();
      int dn;
      logic [27:0] fr;
      bit ok;
      dn = 0;
      pulse_load(8'hF3);
      for (int i = 0; i < 3; i++) begin
         if (done === 1'b1) dn++;
         @(negedge clk);
      end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (done === 1'b1) dn++;
      end
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) dn++;
         total++;
         if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_busy cyc=%0d busy=%b want 0", i, busy);
         end
      end
      total++;
      if (dn != 0) begin
         bad++;
         $display("FAIL rstmid_done done_pulses=%0d want 0", dn);
      end
      read_frame(fr, ok);
      total++;
      if (!ok || fr !== {SB, SB, SB, SB}) begin
         bad++;
         $display("FAIL rstmid_blank frame=%h ok=%0d want %h", fr, ok, {SB, SB, SB, SB});
      end
      check_conv("after_rst9", 8'h09, {SB, SB, SB, S9});
   endtask

   initial begin
      test_reset();
      test_positive();
      test_negative();
      test_max_zero();
      test_load_during_conv();
      test_reset_mid_conv();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
